// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// LEGv8 instruction fetch stage. Holds the program counter and fetches 32-bit
// instructions from a variable-latency instruction memory. It presents the
// fetched word and its opcode field to the control decoder. When the core
// retires the held instruction, it computes the next PC from the branch
// controls.
//
// Handshake semantics (both directions sampled only on the rising CLK edge):
//   - Memory side: imem_req/imem_addr are asserted for every cycle spent in
//     FETCH. An imem_ack seen on an edge while imem_req=1 completes the fetch,
//     and imem_data is captured on that edge. An ack seen while imem_req=0 is
//     dropped.
//   - Core side: inst_valid=1 means instr/opcode/currentpc describe a fetched
//     instruction. An inst_ready seen on an edge while inst_valid=1 retires it.
//     The branch inputs are consumed on that same edge. inst_ready seen while
//     inst_valid=0 is dropped.
//
// Parameters:
//   START_PC  reset value of the PC (low two bits forced to zero)
//   MAX_WAIT  FETCH cycles without an ack before the sticky fetch error (>=1)
//
// Ports:
//   CLK, reset              clock, asynchronous active-high reset
//   imem_req, imem_addr     fetch request / address (imem_addr == currentpc)
//   imem_ack, imem_data     memory response
//   inst_valid, instr       held instruction
//   opcode                  instr[31:21]
//   currentpc               PC of the instruction being fetched or held
//   inst_ready              core has finished the held instruction
//   branch, uncond_branch   CBZ / B from the control decoder
//   alu_zero, extimm        ALU zero flag, sign-extended word offset
//   fetch_err               sticky fetch-timeout error
//   retired                 count of accepted instructions (wraps)
//   fsm_state               current FSM state (IDLE=0, FETCH=1, HOLD=2, ERR=3)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [63:0] START_PC = 64'h0,
  parameter int          MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] instr,
  output logic [10:0] opcode,
  output logic [63:0] currentpc,
  input  logic        inst_ready,
  input  logic        branch,
  input  logic        uncond_branch,
  input  logic        alu_zero,
  input  logic [63:0] extimm,
  output logic        fetch_err,
  output logic [31:0] retired,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam int              WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [63:0]     RESET_PC  = START_PC & ~64'h3;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [63:0]       pc;
  logic [63:0]       next_pc;

  // Unconditional branch takes priority. A conditional branch is taken only
  // when the ALU reports zero (CBZ). All additions wrap modulo 2^64.
  always_comb begin
    next_pc = pc + 64'd4;
    if (uncond_branch || (branch && alu_zero)) begin
      next_pc = pc + (extimm << 2);
    end
  end

  // The request and valid flags are registered alongside the state so that
  // no input reaches an output combinationally.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      instr      <= 32'h0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      retired    <= 32'h0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr      <= imem_data;
            wait_cnt   <= '0;
            state      <= S_HOLD;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            // Timeout: freeze everything until reset.
            state     <= S_ERR;
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc         <= next_pc;
            retired    <= retired + 32'd1;
            state      <= S_FETCH;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
          end
        end
        S_ERR: begin
          // Only reset leaves ERR.
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign currentpc = pc;
  assign opcode    = instr[31:21];
  assign fsm_state = state;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the LEGv8 processor: holds the program counter, fetches 32-bit instructions from a variable-latency instruction memory over a req/ack handshake, and presents the instruction and its 11-bit opcode field (instr[31:21]) to the control decoder and datapath. It sits directly upstream of the control unit. It also consumes that unit's branch/uncond_branch outputs, together with the ALU zero flag and sign-extended immediate, to compute the next PC.

## Interface
- START_PC, 64'h0, PC loaded on reset; bits [1:0] are forced to 0.
- MAX_WAIT, 16, maximum cycles spent in FETCH without imem_ack before a fetch error is raised (>=1).
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch address; always equals currentpc.
- imem_ack  in  1  memory response valid; meaningful only while imem_req=1.
- imem_data  in  32  instruction word; valid when imem_ack=1.
- inst_valid  out  1  instr/opcode hold a fetched instruction.
- instr  out  32  registered instruction word.
- opcode  out  11  instr[31:21], to the control decoder.
- currentpc  out  64  PC of the instruction being fetched or held.
- inst_ready  in  1  core has finished executing the held instruction; branch inputs are valid this cycle.
- branch  in  1  conditional branch (CBZ) from the control decoder.
- uncond_branch  in  1  unconditional branch (B) from the control decoder.
- alu_zero  in  1  ALU zero flag.
- extimm  in  64  sign-extended branch offset, in words.
- fetch_err  out  1  sticky fetch-timeout error.
- retired  out  32  count of instructions accepted via inst_ready.

## Operation
- States: IDLE, FETCH, HOLD, ERR. Reset forces IDLE.
- Reset values:
  - currentpc=START_PC & ~3
  - instr=0, opcode=0
  - inst_valid=0, imem_req=0
  - fetch_err=0, retired=0
  - wait counter=0
- IDLE -> FETCH unconditionally on the first edge after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=currentpc, both decoded from the registered state.
  - On an edge with imem_ack=1: latch imem_data into instr, clear the wait counter, go to HOLD.
  - Otherwise the wait counter increments. When the counter reaches MAX_WAIT-1 with no ack: go to ERR, fetch_err=1.
- HOLD:
  - inst_valid=1, imem_req=0. instr and currentpc stay stable.
  - On an edge with inst_ready=1: load the next PC, increment retired (wraps at 2^32), go to FETCH.
- Next PC, selected in this order:
  - uncond_branch=1: currentpc + (extimm<<2).
  - else branch=1 and alu_zero=1: currentpc + (extimm<<2).
  - else: currentpc + 4.
  - All arithmetic is modulo 2^64; wrap-around is silent.
- ERR: imem_req=0, inst_valid=0, all registers frozen. Only reset exits ERR.
- Ignored inputs:
  - imem_ack outside FETCH (a late or spurious ack is dropped).
  - inst_ready outside HOLD.
  - branch, uncond_branch, alu_zero, extimm outside an accepting HOLD edge.
- Reset asserted mid-fetch or mid-hold returns to IDLE immediately; a pending memory response is ignored because imem_req drops.

## Timing
- Minimum fetch latency: ack in the first FETCH cycle -> inst_valid=1 on the next cycle.
- After reset release:
  - cycle 0: IDLE.
  - cycle 1: imem_req=1.
  - earliest inst_valid: cycle 2.
- Throughput: at most one instruction per 2 cycles (FETCH + HOLD).
- inst_ready and imem_ack are sampled only on rising CLK.
- Outputs are registered or decoded from the registered state. There is no combinational path from any input to any output.
- Simultaneous uncond_branch and branch: uncond_branch wins.

## Test plan
- Reset with START_PC=64'h103, ack in the first FETCH cycle with imem_data=32'h8B020020 -> currentpc=64'h100, inst_valid at cycle 2, opcode=11'h458.
- Sequential fetch: accept 3 instructions with no branch inputs -> imem_addr sequence 0x0, 0x4, 0x8; retired=3.
- CBZ at PC 0x10, extimm=-2:
  - alu_zero=1 -> next imem_addr=0x8.
  - repeat with alu_zero=0 -> next imem_addr=0x14.
- B at PC 0x20 with extimm=5 and branch=1, alu_zero=0 asserted together -> next imem_addr=0x34. Also check PC wrap: PC=64'hFFFF_FFFF_FFFF_FFFC, no branch -> 0x0.
- Variable latency and timeout with MAX_WAIT=4:
  - ack after 3 wait cycles -> HOLD.
  - no ack -> fetch_err=1 after 4 FETCH cycles; a later ack and inst_ready are ignored; reset clears fetch_err.
- Spurious handshakes and mid-op reset:
  - ack while in HOLD -> instr unchanged.
  - inst_ready while in FETCH -> PC unchanged.
  - reset pulse mid-FETCH -> all outputs return to reset values asynchronously.
